// File: rtl/digit_serializer.sv
// Serializes four parallel digits over a valid/ready stream.
// Define BLANK_SKIP_EN to suppress slots holding BLANK_VAL.
module digit_serializer #(
    parameter logic [3:0] BLANK_VAL = 4'hF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ce,
    input  logic       load,
    input  logic [3:0] d1,
    input  logic [3:0] d2,
    input  logic [3:0] d3,
    input  logic [3:0] d4,
    output logic [3:0] out_digit,
    output logic [1:0] out_idx,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [1:0]      idx_q, idx_d;
    logic [3:0][3:0] slot_q, slot_d;

`ifdef BLANK_SKIP_EN
    // Returns {found, slot} of the lowest non-blank slot at or above start.
    function automatic logic [2:0] find_nb(
        input logic [3:0][3:0] s,
        input logic [2:0]      start
    );
        logic [2:0] r;
        r = 3'b000;
        for (int i = 3; i >= 0; i--) begin
            if (i >= int'(start) && s[i] != BLANK_VAL)
                r = {1'b1, i[1:0]};
        end
        return r;
    endfunction

    logic [2:0] ld_sel;
    logic [2:0] nx_sel;

    assign ld_sel = find_nb({d4, d3, d2, d1}, 3'd0);
    assign nx_sel = find_nb(slot_q, {1'b0, idx_q} + 3'd1);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= 2'd0;
            slot_q  <= {4{BLANK_VAL}};
        end else if (ce) begin
            state_q <= state_d;
            idx_q   <= idx_d;
            slot_q  <= slot_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        slot_d  = slot_q;
        unique case (state_q)
            IDLE: begin
                if (load) begin
                    slot_d = {d4, d3, d2, d1};
`ifdef BLANK_SKIP_EN
                    if (ld_sel[2]) begin
                        idx_d   = ld_sel[1:0];
                        state_d = SEND;
                    end else begin
                        state_d = DONE;
                    end
`else
                    idx_d   = 2'd0;
                    state_d = SEND;
`endif
                end
            end
            SEND: begin
                if (out_ready) begin
`ifdef BLANK_SKIP_EN
                    if (nx_sel[2])
                        idx_d = nx_sel[1:0];
                    else
                        state_d = DONE;
`else
                    if (idx_q == 2'd3)
                        state_d = DONE;
                    else
                        idx_d = idx_q + 2'd1;
`endif
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign out_valid = (state_q == SEND);
    assign out_digit = out_valid ? slot_q[idx_q] : BLANK_VAL;
    assign out_idx   = idx_q;
    assign busy      = (state_q == SEND) || (state_q == DONE);
    assign done      = (state_q == DONE);

endmodule
